// File: rtl/decode_id_ex_pkg.sv
// Shared constants for the RV32I decode stage: ALU function codes, base
// opcodes and branch-type codes, plus the funct3-to-ALU mapping.
package decode_id_ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_EQ   = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_JAL  = 3'd5;
  localparam logic [2:0] BR_JALR = 3'd6;

  // alt is inst[30]; allow_sub is set only for register-register ops.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       alt,
                                                 input logic       allow_sub);
    logic [3:0] f;
    case (f3)
      3'b000:  f = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  f = ALU_SLL;
      3'b010:  f = ALU_SLT;
      3'b011:  f = ALU_SLTU;
      3'b100:  f = ALU_XOR;
      3'b101:  f = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f = ALU_OR;
      default: f = ALU_AND;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_id_ex_imm_gen.sv
// Immediate extraction: picks the I/S/B/U/J immediate that matches the
// opcode and sign-extends it from inst[31] to WIDTH.
module decode_id_ex_imm_gen
  import decode_id_ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      inst,
  output logic [WIDTH-1:0] imm
);

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;
  logic signed [31:0] imm_sel;

  always_comb begin
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: imm_sel = imm_u;
      OPC_JAL:            imm_sel = imm_j;
      OPC_BRANCH:         imm_sel = imm_b;
      OPC_STORE:          imm_sel = imm_s;
      default:            imm_sel = imm_i;
    endcase

    imm = WIDTH'(imm_sel);
  end

endmodule

// File: rtl/decode_id_ex.sv
// RV32I decode stage and ID/EX pipeline register: produces registered ALU
// operands/function plus memory, write-back and branch control for execute.
module decode_id_ex
  import decode_id_ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic [WIDTH-1:0] id_pc,
  output logic [4:0]       rf_rs1_addr,
  output logic [4:0]       rf_rs2_addr,
  input  logic [WIDTH-1:0] rf_rs1_data,
  input  logic [WIDTH-1:0] rf_rs2_data,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_func,
  output logic [WIDTH-1:0] ex_alu_src1,
  output logic [WIDTH-1:0] ex_alu_src2,
  output logic [WIDTH-1:0] ex_imm,
  output logic [WIDTH-1:0] ex_rs2_data,
  output logic [WIDTH-1:0] ex_pc,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_we,
  output logic             ex_mem_re,
  output logic             ex_mem_we,
  output logic [2:0]       ex_mem_size,
  output logic [2:0]       ex_br_type,
  output logic             ex_illegal,
  output logic [31:0]      dec_count
);

  logic [WIDTH-1:0] imm;

  logic [3:0]       dec_alu;
  logic [WIDTH-1:0] dec_src1;
  logic [WIDTH-1:0] dec_src2;
  logic [WIDTH-1:0] dec_imm;
  logic [4:0]       dec_rd;
  logic             dec_reg_we;
  logic             dec_mem_re;
  logic             dec_mem_we;
  logic [2:0]       dec_size;
  logic [2:0]       dec_br;
  logic             dec_ill;

  logic             valid_d,    valid_q;
  logic [3:0]       alu_func_d, alu_func_q;
  logic [WIDTH-1:0] src1_d,     src1_q;
  logic [WIDTH-1:0] src2_d,     src2_q;
  logic [WIDTH-1:0] imm_d,      imm_q;
  logic [WIDTH-1:0] rs2_data_d, rs2_data_q;
  logic [WIDTH-1:0] pc_d,       pc_q;
  logic [4:0]       rd_d,       rd_q;
  logic             reg_we_d,   reg_we_q;
  logic             mem_re_d,   mem_re_q;
  logic             mem_we_d,   mem_we_q;
  logic [2:0]       mem_size_d, mem_size_q;
  logic [2:0]       br_type_d,  br_type_q;
  logic             illegal_d,  illegal_q;
  logic [31:0]      count_d,    count_q;

  assign rf_rs1_addr = id_inst[19:15];
  assign rf_rs2_addr = id_inst[24:20];

  decode_id_ex_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .inst (id_inst),
    .imm  (imm)
  );

  always_comb begin
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_ok;
    f3    = id_inst[14:12];
    f7    = id_inst[31:25];
    f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);

    dec_alu    = ALU_ADD;
    dec_src1   = rf_rs1_data;
    dec_src2   = rf_rs2_data;
    dec_imm    = imm;
    dec_rd     = id_inst[11:7];
    dec_reg_we = 1'b0;
    dec_mem_re = 1'b0;
    dec_mem_we = 1'b0;
    dec_size   = 3'd0;
    dec_br     = BR_NONE;
    dec_ill    = 1'b0;

    case (id_inst[6:0])
      OPC_LUI: begin
        dec_src1   = '0;
        dec_src2   = imm;
        dec_reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec_src1   = id_pc;
        dec_src2   = imm;
        dec_reg_we = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_src1   = id_pc;
        dec_src2   = WIDTH'(32'd4);
        dec_reg_we = 1'b1;
        dec_br     = (id_inst[6:0] == OPC_JAL) ? BR_JAL : BR_JALR;
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000: begin dec_alu = ALU_EQ;   dec_br = BR_BEQ; end
          3'b001: begin dec_alu = ALU_EQ;   dec_br = BR_BNE; end
          3'b100: begin dec_alu = ALU_SLT;  dec_br = BR_BLT; end
          3'b101: begin dec_alu = ALU_SLT;  dec_br = BR_BGE; end
          3'b110: begin dec_alu = ALU_SLTU; dec_br = BR_BLT; end
          3'b111: begin dec_alu = ALU_SLTU; dec_br = BR_BGE; end
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_src2   = imm;
        dec_mem_re = 1'b1;
        dec_reg_we = 1'b1;
        dec_size   = f3;
      end
      OPC_STORE: begin
        dec_src2   = imm;
        dec_mem_we = 1'b1;
        dec_size   = f3;
      end
      OPC_OP_IMM: begin
        dec_alu    = alu_from_funct3(f3, id_inst[30], 1'b0);
        dec_src2   = imm;
        dec_reg_we = 1'b1;
        // Shift immediates carry only the shamt; the upper bits are funct7.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec_src2 = WIDTH'(id_inst[24:20]);
          if (!f7_ok || (f3 == 3'b001 && f7 != 7'b0000000))
            dec_ill = 1'b1;
        end
      end
      OPC_OP: begin
        dec_alu    = alu_from_funct3(f3, id_inst[30], 1'b1);
        dec_reg_we = 1'b1;
        if (!f7_ok)
          dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase

    if (dec_ill) begin
      dec_alu    = ALU_ADD;
      dec_src1   = '0;
      dec_src2   = '0;
      dec_imm    = '0;
      dec_rd     = 5'd0;
      dec_reg_we = 1'b0;
      dec_mem_re = 1'b0;
      dec_mem_we = 1'b0;
      dec_size   = 3'd0;
      dec_br     = BR_NONE;
    end

    if (dec_rd == 5'd0)
      dec_reg_we = 1'b0;
  end

  always_comb begin
    valid_d    = valid_q;
    alu_func_d = alu_func_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    imm_d      = imm_q;
    rs2_data_d = rs2_data_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    reg_we_d   = reg_we_q;
    mem_re_d   = mem_re_q;
    mem_we_d   = mem_we_q;
    mem_size_d = mem_size_q;
    br_type_d  = br_type_q;
    illegal_d  = illegal_q;
    count_d    = count_q;

    // Flush beats stall; an empty input slot loads the same bubble as flush.
    if (flush || (!stall && !id_valid)) begin
      valid_d    = 1'b0;
      alu_func_d = 4'd0;
      src1_d     = '0;
      src2_d     = '0;
      imm_d      = '0;
      rs2_data_d = '0;
      pc_d       = '0;
      rd_d       = 5'd0;
      reg_we_d   = 1'b0;
      mem_re_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_size_d = 3'd0;
      br_type_d  = BR_NONE;
      illegal_d  = 1'b0;
    end else if (!stall) begin
      valid_d    = 1'b1;
      alu_func_d = dec_alu;
      src1_d     = dec_src1;
      src2_d     = dec_src2;
      imm_d      = dec_imm;
      rs2_data_d = rf_rs2_data;
      pc_d       = id_pc;
      rd_d       = dec_rd;
      reg_we_d   = dec_reg_we;
      mem_re_d   = dec_mem_re;
      mem_we_d   = dec_mem_we;
      mem_size_d = dec_size;
      br_type_d  = dec_br;
      illegal_d  = dec_ill;
      count_d    = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      alu_func_q <= 4'd0;
      src1_q     <= '0;
      src2_q     <= '0;
      imm_q      <= '0;
      rs2_data_q <= '0;
      pc_q       <= '0;
      rd_q       <= 5'd0;
      reg_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_size_q <= 3'd0;
      br_type_q  <= 3'd0;
      illegal_q  <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      alu_func_q <= alu_func_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      imm_q      <= imm_d;
      rs2_data_q <= rs2_data_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      reg_we_q   <= reg_we_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      mem_size_q <= mem_size_d;
      br_type_q  <= br_type_d;
      illegal_q  <= illegal_d;
      count_q    <= count_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_alu_func = alu_func_q;
  assign ex_alu_src1 = src1_q;
  assign ex_alu_src2 = src2_q;
  assign ex_imm      = imm_q;
  assign ex_rs2_data = rs2_data_q;
  assign ex_pc       = pc_q;
  assign ex_rd       = rd_q;
  assign ex_reg_we   = reg_we_q;
  assign ex_mem_re   = mem_re_q;
  assign ex_mem_we   = mem_we_q;
  assign ex_mem_size = mem_size_q;
  assign ex_br_type  = br_type_q;
  assign ex_illegal  = illegal_q;
  assign dec_count   = count_q;

endmodule
